mc_seq_ctrl: RTL and testbench
==============================

Name: mc_seq_ctrl

Overview:
Multi-cycle sequencer for the simplified RISC-V core. It replaces single-cycle pc/regfile strobing with a state machine, so one unified memory port can serve both instruction fetch and load/store. It sits beside the instruction register, the ALU and the register bank. It consumes opcode/funct3 and branch compare flags, and drives one-cycle enables and mux selects per instruction phase.

Parameters:
TIMEOUT, 16, max wait cycles for mem_gnt/mem_rvalid before bus error; 0 disables the timeout
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
opcode  in  7  from instruction register (stable from DECODE onward)
funct3  in  3  from instruction register
ops_equal  in  1  rs1 == rs2 flag
op1_lt_op2  in  1  signed/unsigned less-than flag, per funct3
mem_req  out  1  memory request, held until granted
mem_we  out  1  write request (valid with mem_req)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
ir_wen  out  1  latch fetched instruction
dr_wen  out  1  latch load data register
reg_wen  out  1  register bank write strobe
reg_wdata_src  out  2  00 ALU, 01 data reg, 10 PC+4
pc_wen  out  1  PC update strobe
pc_src  out  2  00 PC+4, 01 branch/jump target, 10 JALR target
retire  out  1  one-cycle pulse per completed instruction
instret  out  CNT_WIDTH  retired instruction count
halted  out  1  sequencer stopped (sticky)
illegal_instr  out  1  halt cause: unknown opcode (sticky)
bus_err  out  1  halt cause: memory timeout (sticky)

Behaviour:
- State register uses states FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT. Outputs are combinational from state plus gnt/rvalid/flags. All strobes default 0.
- Reset: while rst=1, all outputs are 0 and instret=0. State is FETCH on the first cycle after rst falls.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. On mem_gnt go to IWAIT.
- IWAIT: on mem_rvalid, pulse ir_wen and go to DECODE.
- DECODE: one cycle.
  - Opcode in {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR}: go to EXEC.
  - Any other opcode: go to HALT and set illegal_instr.
- EXEC, one cycle:
  - OP, OP_IMM, JAL, JALR: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: pulse pc_wen and retire, go to FETCH. pc_src=01 if taken, else 00.
  - Taken rules: beq ops_equal; bne !ops_equal; blt/bltu op1_lt_op2; bge/bgeu !op1_lt_op2. funct3 2 or 3 is not taken.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(opcode==STORE).
  - STORE with mem_gnt: pc_wen=1, pc_src=00, retire=1, go to FETCH.
  - LOAD with mem_gnt: go to MWAIT.
- MWAIT: on mem_rvalid, pulse dr_wen and go to WB.
- WB: one cycle. reg_wen=1, pc_wen=1, retire=1, then go to FETCH.
  - reg_wdata_src: 00 for OP/OP_IMM, 01 for LOAD, 10 for JAL/JALR.
  - pc_src: 01 for JAL, 10 for JALR, else 00.
- Minimum latency with gnt same-cycle and rvalid next cycle:
  - OP/OP_IMM/JAL/JALR: 5 cycles.
  - BRANCH: 4 cycles.
  - STORE: 5 cycles.
  - LOAD: 7 cycles.
- Timeout counter, width $clog2(TIMEOUT+1):
  - Increments each cycle spent in FETCH, IWAIT, MEM or MWAIT without the awaited event; clears on every state change.
  - Reaching TIMEOUT goes to HALT and sets bus_err.
  - If the awaited event and the timeout occur in the same cycle, the event wins.
- HALT: mem_req=0, all strobes 0, halted=1. Only rst exits HALT.
- instret increments on retire and wraps modulo 2^CNT_WIDTH.
- mem_rvalid in any non-waiting state, or mem_gnt with mem_req=0, is ignored.
- rst mid-transaction: mem_req drops in the same cycle rst is sampled; no strobe fires.
- Sticky flags clear only on rst.

Decomposition:
- Add mc_state_t enum to typedefs_pkg.
- Reuse the existing opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR) from typedefs_pkg.
- One sub-module, branch_resolve: combinational funct3 + flags -> taken. It is shared with the existing single-cycle control path.

Test Plan:
- ADD (OP, funct3=0), gnt same cycle, rvalid next cycle -> ir_wen in cycle 2; reg_wen/pc_wen/retire in cycle 5 with reg_wdata_src=00, pc_src=00; instret=1.
- LOAD, data gnt delayed 3 cycles -> mem_req held with mem_addr_sel=1 for 4 cycles; dr_wen on rvalid; WB next cycle with reg_wdata_src=01.
- BEQ with ops_equal=1, then BNE with ops_equal=1 -> first has pc_src=01 in EXEC, second pc_src=00; both retire in 4 cycles.
- Opcode 7'h7F fetched -> HALT after DECODE, illegal_instr=1, no further mem_req for 20 cycles.
- TIMEOUT=16, rvalid never returns in IWAIT -> bus_err=1 and halted=1 after 16 IWAIT cycles; rvalid arriving in cycle 16 instead -> no error.
- rst asserted during MEM with STORE pending -> mem_req=0 that cycle, no retire, instret=0; FETCH restarts after rst falls.

Source files
------------

// File: rtl/typedefs_pkg.sv
// Shared core typedefs: RV32I major opcodes, funct3 branch codes, control-mux encodings
// and the multi-cycle sequencer state type.
package typedefs_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [1:0] WDATA_ALU = 2'b00;
  localparam logic [1:0] WDATA_DR  = 2'b01;
  localparam logic [1:0] WDATA_PC4 = 2'b10;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_TGT  = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  typedef enum logic [2:0] {
    FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT
  } mc_state_t;

  // Opcodes the sequencer knows how to step through.
  function automatic logic is_known_opcode(input logic [6:0] op);
    return op inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition from funct3 and comparator flags; shared with the single-cycle path.
module branch_resolve
  import typedefs_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       ops_equal,
  input  logic       op1_lt_op2,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = ops_equal;
      F3_BNE:           taken = !ops_equal;
      F3_BLT, F3_BLTU:  taken = op1_lt_op2;
      F3_BGE, F3_BGEU:  taken = !op1_lt_op2;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle instruction sequencer: one shared memory port for fetch and load/store,
// per-phase strobes and mux selects, retire counting and sticky halt causes.
module mc_seq_ctrl
  import typedefs_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 ops_equal,
  input  logic                 op1_lt_op2,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  output logic                 ir_wen,
  output logic                 dr_wen,
  output logic                 reg_wen,
  output logic [1:0]           reg_wdata_src,
  output logic                 pc_wen,
  output logic [1:0]           pc_src,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 halted,
  output logic                 illegal_instr,
  output logic                 bus_err
);

  localparam int unsigned TMO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  mc_state_t            state_q, state_d;
  logic [TMO_W-1:0]     tmo_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic                 illegal_q, bus_err_q;
  logic                 taken, waiting, evt, tmo_hit;
  logic                 set_illegal, set_bus_err;

  branch_resolve u_branch_resolve (
    .funct3     (funct3),
    .ops_equal  (ops_equal),
    .op1_lt_op2 (op1_lt_op2),
    .taken      (taken)
  );

  // Last tolerated wait cycle; an awaited event in this same cycle still wins.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Outputs are gated by rst so a pending request drops in the cycle reset is sampled.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_wen        = 1'b0;
    dr_wen        = 1'b0;
    reg_wen       = 1'b0;
    reg_wdata_src = WDATA_ALU;
    pc_wen        = 1'b0;
    pc_src        = PC_SRC_PC4;
    retire        = 1'b0;
    halted        = 1'b0;
    illegal_instr = 1'b0;
    bus_err       = 1'b0;
    instret       = '0;
    waiting       = 1'b0;
    evt           = 1'b0;
    set_illegal   = 1'b0;
    set_bus_err   = 1'b0;
    if (!rst) begin
      illegal_instr = illegal_q;
      bus_err       = bus_err_q;
      instret       = instret_q;
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          waiting = 1'b1;
          evt     = mem_gnt;
          if (evt)          state_d = IWAIT;
          else if (tmo_hit) begin state_d = HALT; set_bus_err = 1'b1; end
        end
        IWAIT: begin
          waiting = 1'b1;
          evt     = mem_rvalid;
          if (evt)          begin ir_wen = 1'b1; state_d = DECODE; end
          else if (tmo_hit) begin state_d = HALT; set_bus_err = 1'b1; end
        end
        DECODE: begin
          if (is_known_opcode(opcode)) state_d = EXEC;
          else begin state_d = HALT; set_illegal = 1'b1; end
        end
        EXEC: begin
          if (opcode == BRANCH) begin
            pc_wen  = 1'b1;
            retire  = 1'b1;
            pc_src  = taken ? PC_SRC_TGT : PC_SRC_PC4;
            state_d = FETCH;
          end else if (opcode == LOAD || opcode == STORE) begin
            state_d = MEM;
          end else begin
            state_d = WB;
          end
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == STORE);
          waiting      = 1'b1;
          evt          = mem_gnt;
          if (evt) begin
            if (opcode == STORE) begin
              pc_wen  = 1'b1;
              retire  = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = MWAIT;
            end
          end else if (tmo_hit) begin
            state_d = HALT; set_bus_err = 1'b1;
          end
        end
        MWAIT: begin
          waiting = 1'b1;
          evt     = mem_rvalid;
          if (evt)          begin dr_wen = 1'b1; state_d = WB; end
          else if (tmo_hit) begin state_d = HALT; set_bus_err = 1'b1; end
        end
        WB: begin
          reg_wen = 1'b1;
          pc_wen  = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
          if (opcode == LOAD)                     reg_wdata_src = WDATA_DR;
          else if (opcode == JAL || opcode == JALR) reg_wdata_src = WDATA_PC4;
          if (opcode == JAL)       pc_src = PC_SRC_TGT;
          else if (opcode == JALR) pc_src = PC_SRC_JALR;
        end
        HALT: halted = 1'b1;
        default: state_d = HALT;
      endcase
    end
  end

  // Wait-cycle counter, retire counter and sticky halt causes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_q <= (waiting && (state_d == state_q)) ? tmo_q + TMO_W'(1) : '0;
      if (retire)      instret_q <= instret_q + CNT_WIDTH'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: directed instructions push expected events,
// a negedge monitor pops and compares whenever the sequencer shows activity.
module tb_mc_seq_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        ops_equal, op1_lt_op2;
  logic        mem_req, mem_we, mem_addr_sel, mem_gnt, mem_rvalid;
  logic        ir_wen, dr_wen, reg_wen, pc_wen, retire;
  logic [1:0]  reg_wdata_src, pc_src;
  logic [31:0] instret;
  logic        halted, illegal_instr, bus_err;

  mc_seq_ctrl #(.TIMEOUT(TMO), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .ops_equal(ops_equal), .op1_lt_op2(op1_lt_op2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .ir_wen(ir_wen), .dr_wen(dr_wen), .reg_wen(reg_wen),
    .reg_wdata_src(reg_wdata_src), .pc_wen(pc_wen), .pc_src(pc_src),
    .retire(retire), .instret(instret), .halted(halted),
    .illegal_instr(illegal_instr), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic hs, we, sel, ir, dr, rw;
    logic [1:0] src;
    logic pw;
    logic [1:0] psrc;
    logic ret, hr, ill, be;
  } ev_t;

  typedef struct {
    int          cyc;
    ev_t         ev;
    int unsigned cnt;
  } rec_t;

  typedef enum int {K_WB, K_BR, K_ST, K_LD, K_ILL, K_TO} kind_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       eq, lt;
    int         di, dd;
    kind_t      kind;
    logic [1:0] src, psrc;
  } vec_t;

  rec_t        sb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int unsigned retired = 0;
  logic        halted_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reset quiet check, halt quiet check, and event scoreboard compare.
  always @(negedge clk) begin : mon
    ev_t  ob;
    rec_t r;
    if (rst) begin
      n_cmp++;
      if ({mem_req, mem_we, mem_addr_sel, ir_wen, dr_wen, reg_wen, reg_wdata_src,
           pc_wen, pc_src, retire, halted, illegal_instr, bus_err} != '0 || instret != 32'd0) begin
        n_mis++;
        $display("FAIL reset_outputs cyc=%0d req=%0b strobes=%0b%0b%0b%0b%0b halted=%0b instret=%0d required all 0",
                 cyc, mem_req, ir_wen, dr_wen, reg_wen, pc_wen, retire, halted, instret);
      end
      halted_d = 1'b0;
    end else begin
      ob      = '0;
      ob.hs   = mem_req & mem_gnt;
      ob.we   = ob.hs & mem_we;
      ob.sel  = ob.hs & mem_addr_sel;
      ob.ir   = ir_wen;
      ob.dr   = dr_wen;
      ob.rw   = reg_wen;
      ob.src  = reg_wdata_src;
      ob.pw   = pc_wen;
      ob.psrc = pc_src;
      ob.ret  = retire;
      ob.hr   = halted & ~halted_d;
      ob.ill  = ob.hr & illegal_instr;
      ob.be   = ob.hr & bus_err;
      if (halted) begin
        n_cmp++;
        if (mem_req | ir_wen | dr_wen | reg_wen | pc_wen | retire | !(illegal_instr | bus_err)) begin
          n_mis++;
          $display("FAIL halt_quiet cyc=%0d req=%0b strobes=%0b%0b%0b%0b%0b cause=%0b%0b required quiet with a cause",
                   cyc, mem_req, ir_wen, dr_wen, reg_wen, pc_wen, retire, illegal_instr, bus_err);
        end
      end
      if (ob != '0) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_event cyc=%0d got=%h required none", cyc, ob);
        end else begin
          r = sb_q.pop_front();
          if (r.cyc != cyc || r.ev != ob || instret != 32'(r.cnt)) begin
            n_mis++;
            $display("FAIL event cyc=%0d got=%h instret=%0d required cyc=%0d ev=%h instret=%0d",
                     cyc, ob, instret, r.cyc, r.ev, r.cnt);
          end
        end
      end
      halted_d = halted;
    end
  end

  task automatic push(input int c, input ev_t e);
    rec_t r;
    r.cyc = c;
    r.ev  = e;
    r.cnt = retired;
    sb_q.push_back(r);
  endtask

  // Set handshake inputs for the current cycle, then advance one cycle.
  task automatic drive(input logic g, input logic r);
    mem_gnt    = g;
    mem_rvalid = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    opcode = 7'h00; funct3 = 3'd0; ops_equal = 1'b0; op1_lt_op2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    retired = 0;
  endtask

  function automatic vec_t mkv(input logic [6:0] op, input logic [2:0] f3, input logic eq,
                               input logic lt, input int di, input int dd, input kind_t k,
                               input logic [1:0] src, input logic [1:0] psrc);
    vec_t v;
    v.op = op; v.f3 = f3; v.eq = eq; v.lt = lt; v.di = di; v.dd = dd;
    v.kind = k; v.src = src; v.psrc = psrc;
    return v;
  endfunction

  // One instruction starting in FETCH: push its expected events, then drive handshakes.
  task automatic run(input vec_t v);
    int  s, b;
    ev_t e;
    s = cyc;
    b = s + 2 + v.di;
    opcode = v.op; funct3 = v.f3; ops_equal = v.eq; op1_lt_op2 = v.lt;
    e = '0; e.hs = 1'b1; push(s, e);
    if (v.kind == K_TO) begin
      e = '0; e.hr = 1'b1; e.be = 1'b1; push(s + 1 + TMO, e);
      drive(1'b1, 1'b0);
      repeat (TMO) drive(1'b0, 1'b0);
      repeat (4) drive(1'b1, 1'b1);
    end else begin
      e = '0; e.ir = 1'b1; push(s + 1 + v.di, e);
      case (v.kind)
        K_ILL: begin e = '0; e.hr = 1'b1; e.ill = 1'b1; push(b + 1, e); end
        K_WB: begin
          e = '0; e.rw = 1'b1; e.src = v.src; e.pw = 1'b1; e.psrc = v.psrc; e.ret = 1'b1;
          push(b + 2, e); retired++;
        end
        K_BR: begin
          e = '0; e.pw = 1'b1; e.psrc = v.psrc; e.ret = 1'b1;
          push(b + 1, e); retired++;
        end
        K_ST: begin
          e = '0; e.hs = 1'b1; e.we = 1'b1; e.sel = 1'b1; e.pw = 1'b1; e.psrc = v.psrc; e.ret = 1'b1;
          push(b + 2 + v.dd, e); retired++;
        end
        default: begin
          e = '0; e.hs = 1'b1; e.sel = 1'b1; push(b + 2 + v.dd, e);
          e = '0; e.dr = 1'b1; push(b + 3 + v.dd, e);
          e = '0; e.rw = 1'b1; e.src = v.src; e.pw = 1'b1; e.psrc = v.psrc; e.ret = 1'b1;
          push(b + 4 + v.dd, e); retired++;
        end
      endcase
      drive(1'b1, 1'b0);
      repeat (v.di) drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      // Stray gnt/rvalid outside awaited phases must be ignored.
      case (v.kind)
        K_ILL: repeat (20) drive(1'b1, 1'b1);
        K_WB:  begin drive(1'b1, 1'b1); drive(1'b0, 1'b0); drive(1'b0, 1'b1); end
        K_BR:  begin drive(1'b1, 1'b1); drive(1'b0, 1'b1); end
        K_ST:  begin
          drive(1'b1, 1'b1); drive(1'b0, 1'b0);
          repeat (v.dd) drive(1'b0, 1'b1);
          drive(1'b1, 1'b0);
        end
        default: begin
          drive(1'b1, 1'b1); drive(1'b0, 1'b0);
          repeat (v.dd) drive(1'b0, 1'b0);
          drive(1'b1, 1'b0); drive(1'b0, 1'b1); drive(1'b1, 1'b0);
        end
      endcase
    end
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = mkv(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, K_WB, 2'b00, 2'b00); // add
    vecs[1]  = mkv(7'h03, 3'd2, 1'b0, 1'b0, 0, 3, K_LD, 2'b01, 2'b00); // lw, gnt late by 3
    vecs[2]  = mkv(7'h63, 3'd0, 1'b1, 1'b0, 0, 0, K_BR, 2'b00, 2'b01); // beq taken
    vecs[3]  = mkv(7'h63, 3'd1, 1'b1, 1'b0, 0, 0, K_BR, 2'b00, 2'b00); // bne not taken
    vecs[4]  = mkv(7'h23, 3'd2, 1'b0, 1'b0, 0, 0, K_ST, 2'b00, 2'b00); // sw
    vecs[5]  = mkv(7'h6F, 3'd0, 1'b0, 1'b0, 0, 0, K_WB, 2'b10, 2'b01); // jal
    vecs[6]  = mkv(7'h67, 3'd0, 1'b0, 1'b0, 0, 0, K_WB, 2'b10, 2'b10); // jalr
    vecs[7]  = mkv(7'h13, 3'd0, 1'b0, 1'b0, 0, 0, K_WB, 2'b00, 2'b00); // addi
    vecs[8]  = mkv(7'h63, 3'd4, 1'b0, 1'b1, 0, 0, K_BR, 2'b00, 2'b01); // blt taken
    vecs[9]  = mkv(7'h63, 3'd7, 1'b0, 1'b1, 0, 0, K_BR, 2'b00, 2'b00); // bgeu not taken
    vecs[10] = mkv(7'h63, 3'd2, 1'b1, 1'b1, 0, 0, K_BR, 2'b00, 2'b00); // funct3=2 never taken
    vecs[11] = mkv(7'h63, 3'd5, 1'b0, 1'b0, 0, 0, K_BR, 2'b00, 2'b01); // bge taken
    vecs[12] = mkv(7'h23, 3'd2, 1'b0, 1'b0, 0, 2, K_ST, 2'b00, 2'b00); // sw, gnt late by 2
    vecs[13] = mkv(7'h03, 3'd2, 1'b0, 1'b0, 2, 0, K_LD, 2'b01, 2'b00); // lw, slow fetch

    rst = 1'b1;
    do_reset();
    foreach (vecs[i]) run(vecs[i]);
    run(mkv(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, K_ILL, 2'b00, 2'b00));

    do_reset();
    run(mkv(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, K_TO, 2'b00, 2'b00));

    do_reset();
    run(mkv(7'h33, 3'd0, 1'b0, 1'b0, TMO - 1, 0, K_WB, 2'b00, 2'b00)); // rvalid on last wait cycle

    // Reset while a store waits for its grant in MEM.
    do_reset();
    opcode = 7'h23; funct3 = 3'd2;
    begin
      ev_t e;
      e = '0; e.hs = 1'b1; push(cyc, e);
      e = '0; e.ir = 1'b1; push(cyc + 1, e);
    end
    drive(1'b1, 1'b0); drive(1'b0, 1'b1); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rst = 1'b1; mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    run(vecs[0]);

    repeat (2) drive(1'b0, 1'b0);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL leftover_events got=%0d required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
